// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared types and defaults for the Pong match sequencer:
//                match state encoding, default scoring/hold constants and
//                the hold-timer width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int WIN_SCORE_DEF = 5;
    localparam int GOAL_HOLD_DEF = 26;
    localparam int WIN_HOLD_DEF  = 32;
    localparam int HOLD_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_GOAL_HOLD = 3'd2,
        ST_WIN_HOLD  = 3'd3,
        ST_GAME_OVER = 3'd4
    } match_state_t;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hold_timer
//  Description : Loadable down-counter that times the post-goal and post-win
//                freezes. Counts down to zero and parks there; done is high
//                whenever the count is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hold_timer
    import pong_pkg::*;
(
    input  logic              BALL_CLOCK,
    input  logic              RESET,
    input  logic              load,
    input  logic [HOLD_W-1:0] value,
    output logic              done
);

    logic [HOLD_W-1:0] r_count;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge BALL_CLOCK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule : hold_timer
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : match_controller
//  Description : Pong match sequencer. Counts goals, keeps both scores,
//                emits one-cycle goal/win pulses to the animation block,
//                freezes the ball during animations and picks the serve
//                direction for the next rally. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE = WIN_SCORE_DEF,
    parameter int SCORE_W   = 4,
    parameter int GOAL_HOLD = GOAL_HOLD_DEF,
    parameter int WIN_HOLD  = WIN_HOLD_DEF
) (
    input  logic               BALL_CLOCK,
    input  logic               RESET,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               goal_player_1,
    output logic               goal_player_2,
    output logic               win_player_1,
    output logic               win_player_2,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               ball_enable,
    output logic               serve_left,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] c_win_score = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  c_goal_load = HOLD_W'(GOAL_HOLD - 1);
    localparam logic [HOLD_W-1:0]  c_win_load  = HOLD_W'(WIN_HOLD - 1);

    match_state_t       r_state, w_state_n;
    logic [SCORE_W-1:0] r_score_1, w_score_1_n;
    logic [SCORE_W-1:0] r_score_2, w_score_2_n;
    logic               r_goal_1, w_goal_1_n;
    logic               r_goal_2, w_goal_2_n;
    logic               r_win_1, w_win_1_n;
    logic               r_win_2, w_win_2_n;
    logic               r_ball_en, w_ball_en_n;
    logic               r_serve_left, w_serve_left_n;
    logic               r_game_over, w_game_over_n;

    logic               w_load;
    logic [HOLD_W-1:0]  w_load_val;
    logic               w_hold_done;
    logic               w_one_miss;
    logic [SCORE_W-1:0] w_new_score;

    // One timer serves both freezes; only one can be running at a time.
    hold_timer u_hold_timer (
        .BALL_CLOCK (BALL_CLOCK),
        .RESET      (RESET),
        .load       (w_load),
        .value      (w_load_val),
        .done       (w_hold_done)
    );

    // A simultaneous double miss is ambiguous and is discarded.
    assign w_one_miss  = miss_left ^ miss_right;
    // miss_right means player 1 scores; miss_left means player 2 scores.
    assign w_new_score = (miss_right ? r_score_1 : r_score_2) + 1'b1;

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        w_state_n      = r_state;
        w_score_1_n    = r_score_1;
        w_score_2_n    = r_score_2;
        w_goal_1_n     = 1'b0;
        w_goal_2_n     = 1'b0;
        w_win_1_n      = 1'b0;
        w_win_2_n      = 1'b0;
        w_ball_en_n    = r_ball_en;
        w_serve_left_n = r_serve_left;
        w_game_over_n  = r_game_over;
        w_load         = 1'b0;
        w_load_val     = '0;

        case (r_state)
            ST_IDLE: begin
                if (start_btn) begin
                    w_state_n   = ST_PLAY;
                    w_score_1_n = '0;
                    w_score_2_n = '0;
                    w_ball_en_n = 1'b1;
                end
            end

            ST_PLAY: begin
                if (w_one_miss) begin
                    w_ball_en_n    = 1'b0;
                    w_serve_left_n = miss_left;
                    w_load         = 1'b1;
                    if (miss_right) begin
                        w_score_1_n = w_new_score;
                    end else begin
                        w_score_2_n = w_new_score;
                    end
                    if (w_new_score == c_win_score) begin
                        w_state_n  = ST_WIN_HOLD;
                        w_load_val = c_win_load;
                        w_win_1_n  = miss_right;
                        w_win_2_n  = miss_left;
                    end else begin
                        w_state_n  = ST_GOAL_HOLD;
                        w_load_val = c_goal_load;
                        w_goal_1_n = miss_right;
                        w_goal_2_n = miss_left;
                    end
                end
            end

            ST_GOAL_HOLD: begin
                if (w_hold_done) begin
                    w_state_n   = ST_PLAY;
                    w_ball_en_n = 1'b1;
                end
            end

            ST_WIN_HOLD: begin
                if (w_hold_done) begin
                    w_state_n     = ST_GAME_OVER;
                    w_game_over_n = 1'b1;
                end
            end

            ST_GAME_OVER: begin
                if (start_btn) begin
                    w_state_n     = ST_PLAY;
                    w_score_1_n   = '0;
                    w_score_2_n   = '0;
                    w_ball_en_n   = 1'b1;
                    w_game_over_n = 1'b0;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset outranks every input.
    always_ff @(posedge BALL_CLOCK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_score_1    <= '0;
            r_score_2    <= '0;
            r_goal_1     <= 1'b0;
            r_goal_2     <= 1'b0;
            r_win_1      <= 1'b0;
            r_win_2      <= 1'b0;
            r_ball_en    <= 1'b0;
            r_serve_left <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_score_1    <= w_score_1_n;
            r_score_2    <= w_score_2_n;
            r_goal_1     <= w_goal_1_n;
            r_goal_2     <= w_goal_2_n;
            r_win_1      <= w_win_1_n;
            r_win_2      <= w_win_2_n;
            r_ball_en    <= w_ball_en_n;
            r_serve_left <= w_serve_left_n;
            r_game_over  <= w_game_over_n;
        end
    end

    assign goal_player_1 = r_goal_1;
    assign goal_player_2 = r_goal_2;
    assign win_player_1  = r_win_1;
    assign win_player_2  = r_win_2;
    assign score_1       = r_score_1;
    assign score_2       = r_score_2;
    assign ball_enable   = r_ball_en;
    assign serve_left    = r_serve_left;
    assign game_over     = r_game_over;

endmodule : match_controller
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_controller
//  Description : Self-checking bench for match_controller. An event-time
//                model (goal/win timestamps, plain integer scores) predicts
//                every output each cycle; directed literal checks pin the
//                model against the documented scenarios, then random play.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_match_controller;

    localparam int c_win_score = 5;
    localparam int c_score_w   = 4;
    localparam int c_goal_hold = 26;
    localparam int c_win_hold  = 32;

    logic BALL_CLOCK = 1'b0;
    logic RESET      = 1'b1;
    logic start_btn  = 1'b0;
    logic miss_left  = 1'b0;
    logic miss_right = 1'b0;
    logic goal_player_1, goal_player_2, win_player_1, win_player_2;
    logic [c_score_w-1:0] score_1, score_2;
    logic ball_enable, serve_left, game_over;

    int total = 0;
    int bad   = 0;

    match_controller #(
        .WIN_SCORE (c_win_score),
        .SCORE_W   (c_score_w),
        .GOAL_HOLD (c_goal_hold),
        .WIN_HOLD  (c_win_hold)
    ) dut (
        .BALL_CLOCK    (BALL_CLOCK),
        .RESET         (RESET),
        .start_btn     (start_btn),
        .miss_left     (miss_left),
        .miss_right    (miss_right),
        .goal_player_1 (goal_player_1),
        .goal_player_2 (goal_player_2),
        .win_player_1  (win_player_1),
        .win_player_2  (win_player_2),
        .score_1       (score_1),
        .score_2       (score_2),
        .ball_enable   (ball_enable),
        .serve_left    (serve_left),
        .game_over     (game_over)
    );

    always #5 BALL_CLOCK = ~BALL_CLOCK;

    // ------------------------------------------------------------------
    // Reference model: a match is "live" once started; goals stamp the
    // cycle at which the ball is released, wins stamp the cycle at which
    // game over begins. Everything else is derived from those stamps.
    // ------------------------------------------------------------------
    int       cyc       = 0;
    bit       m_started = 0;
    bit       m_won     = 0;
    int       m_s1      = 0;
    int       m_s2      = 0;
    bit       m_serve   = 0;
    int       m_free_at = 0;
    int       m_over_at = 0;
    bit [3:0] m_pulse   = '0;   // {win2, win1, goal2, goal1}
    bit       check_en  = 0;

    function automatic bit m_in_play(int k);
        return m_started && !m_won && (k >= m_free_at);
    endfunction

    function automatic bit m_game_over(int k);
        return m_won && (k >= m_over_at);
    endfunction

    always @(posedge BALL_CLOCK) begin
        bit play_prev;
        bit over_prev;
        play_prev = m_in_play(cyc);
        over_prev = m_game_over(cyc);
        cyc       = cyc + 1;
        m_pulse   = '0;
        if (RESET) begin
            m_started = 0; m_won = 0; m_s1 = 0; m_s2 = 0;
            m_serve = 0; m_free_at = 0; m_over_at = 0;
            check_en = 1;
        end else if (play_prev && (miss_left != miss_right)) begin
            int s;
            m_serve = miss_left;
            if (miss_right) begin m_s1 = m_s1 + 1; s = m_s1; end
            else            begin m_s2 = m_s2 + 1; s = m_s2; end
            if (s == c_win_score) begin
                m_won     = 1;
                m_over_at = cyc + c_win_hold;
                m_pulse   = miss_right ? 4'b0100 : 4'b1000;
            end else begin
                m_free_at = cyc + c_goal_hold;
                m_pulse   = miss_right ? 4'b0001 : 4'b0010;
            end
        end else if (start_btn && (!m_started || over_prev)) begin
            m_started = 1; m_won = 0; m_s1 = 0; m_s2 = 0;
            m_free_at = cyc;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge BALL_CLOCK) begin
        if (check_en) begin
            logic [14:0] act, exp;
            act = {win_player_2, win_player_1, goal_player_2, goal_player_1,
                   score_1, score_2, ball_enable, serve_left, game_over};
            exp = {m_pulse, c_score_w'(m_s1), c_score_w'(m_s2),
                   m_in_play(cyc), m_serve, m_game_over(cyc)};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, act, exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge BALL_CLOCK);
            #1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; tick(); start_btn = 1'b0;
    endtask

    task automatic hit(bit left, bit right);
        miss_left = left; miss_right = right; tick();
        miss_left = 1'b0; miss_right = 1'b0;
    endtask

    // Bounded wait; which: 0 = ball_enable, 1 = game_over.
    task automatic wait_for(int which, string name);
        int n = 0;
        while (((which == 0) ? ball_enable : game_over) !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk({name, "_timeout"}, 0, 1);
    endtask

    function automatic logic [3:0] pulses();
        return {win_player_2, win_player_1, goal_player_2, goal_player_1};
    endfunction

    initial begin
        logic [3:0] seen;

        // 1: reset, then start
        tick(2);
        chk("reset_outputs",
            {pulses(), score_1, score_2, ball_enable, serve_left, game_over}, 0);
        RESET = 1'b0;
        tick();
        press_start();
        chk("start_ball_enable", ball_enable, 1);
        chk("start_scores", {score_1, score_2}, 0);
        chk("start_pulses", pulses(), 0);

        // 2: player 1 scores, freeze lasts exactly GOAL_HOLD cycles
        hit(0, 1);
        chk("goal1_score", score_1, 1);
        chk("goal1_pulses", pulses(), 4'b0001);
        chk("goal1_ball_enable", ball_enable, 0);
        chk("goal1_serve", serve_left, 0);
        tick();
        chk("goal1_pulse_width", pulses(), 0);
        tick(c_goal_hold - 2);
        chk("goal1_still_frozen", ball_enable, 0);
        tick();
        chk("goal1_release", ball_enable, 1);

        // 3: reach 4-0, then the winning point
        for (int i = 0; i < 3; i++) begin
            hit(0, 1);
            wait_for(0, "to_four");
        end
        chk("four_nil", score_1, 4);
        hit(0, 1);
        chk("win1_score", score_1, 5);
        chk("win1_pulses", pulses(), 4'b0100);
        tick(c_win_hold - 1);
        chk("win1_not_over_yet", game_over, 0);
        tick();
        chk("win1_game_over", game_over, 1);
        hit(0, 1);
        chk("win1_score_held", score_1, 5);
        chk("win1_no_pulse_after", pulses(), 0);

        // restart from game over
        press_start();
        chk("restart_scores", {score_1, score_2}, 0);
        chk("restart_game_over", game_over, 0);

        // 4: simultaneous misses ignored; misses during a hold ignored
        hit(1, 1);
        chk("double_miss_scores", {score_1, score_2}, 0);
        chk("double_miss_pulses", pulses(), 0);
        chk("double_miss_ball", ball_enable, 1);
        hit(1, 0);
        chk("goal2_pulses", pulses(), 4'b0010);
        chk("goal2_serve", serve_left, 1);
        tick(3);
        hit(1, 0);
        chk("hold_miss_ignored", score_2, 1);
        wait_for(0, "after_goal2");

        // 5: reset during goal hold with counter at 10
        hit(0, 1);
        tick(c_goal_hold - 1 - 10);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midhold_reset_scores", {score_1, score_2}, 0);
        chk("midhold_reset_ball", ball_enable, 0);
        chk("midhold_reset_pulses", pulses(), 0);
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen |= pulses();
        end
        chk("midhold_no_later_pulse", seen, 0);
        chk("midhold_stays_idle", ball_enable, 0);

        // 6: game over at 2-5, restart keeps serve
        press_start();
        for (int i = 0; i < 2; i++) begin hit(0, 1); wait_for(0, "p1_pts"); end
        for (int i = 0; i < 4; i++) begin hit(1, 0); wait_for(0, "p2_pts"); end
        hit(1, 0);
        chk("win2_pulses", pulses(), 4'b1000);
        wait_for(1, "win2_over");
        chk("final_score", {score_1, score_2}, {4'd2, 4'd5});
        press_start();
        chk("restart2_scores", {score_1, score_2}, 0);
        chk("restart2_flags", {game_over, ball_enable, serve_left}, 3'b011);

        // Random play against the model
        for (int i = 0; i < 5000; i++) begin
            RESET      = ($urandom_range(0, 799) == 0);
            start_btn  = ($urandom_range(0, 19) == 0);
            miss_left  = ($urandom_range(0, 9) == 0);
            miss_right = ($urandom_range(0, 9) == 0);
            tick();
        end
        RESET = 1'b0; start_btn = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_match_controller
`default_nettype wire
